neo_spike_detector: RTL and testbench
=====================================

# neo_spike_detector

Downstream consumer of the NEO energy stream. Takes each signed 16-bit NEO sample as the NEO stage's write enable qualifies it. Derives an adaptive threshold from a block average of recent energy. Emits one event per detected spike, carrying the spike's peak energy and its sample timestamp, then holds off for a refractory period.

## Interface
- Data_width, 16: width of NEO energy input (2× NEO input width).
- Win_log2, 4: threshold window is 2^Win_log2 valid samples.
- Refractory, 8: valid samples ignored after each spike; legal range 1..255.
- TS_width, 16: timestamp counter width.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- Data_in  in  Data_width  signed NEO energy sample.
- Valid  in  1  sample qualifier, driven by NEO write_en; a sample is accepted only on cycles with Valid=1.
- Thr_mult  in  4  unsigned threshold multiplier; sampled at each window end.
- Armed  out  1  threshold valid; detection enabled.
- Spike  out  1  one-cycle event pulse.
- Peak  out  Data_width  peak energy of the last spike; unsigned value, MSB always 0.
- Spike_ts  out  TS_width  timestamp of the peak sample.
- Spike_count  out  8  number of spikes since reset; wraps at 255→0.

## Operation
- Clamp: accepted sample x = max(Data_in, 0); negative NEO values count as 0 everywhere.
- Timestamp: ts increments by 1 per accepted sample and wraps modulo 2^TS_width. The first accepted sample after reset has ts=0.
- Accumulator: width Data_width+Win_log2, unsigned; sums x over each window of 2^Win_log2 accepted samples.
- Window end: on the last sample of a window:
  - Thr <= (sum_including_this_sample >> Win_log2) * Thr_mult, width Data_width+4, no saturation.
  - The accumulator restarts at 0.
- Windows run continuously in every state.
- "Above" means x > Thr, strictly; equality is not above. Every comparison uses the Thr register value from before any same-cycle update.
- FSM states:
  - WARMUP (reset state): go to ARMED when the first window completes.
  - ARMED: on an accepted sample with x above Thr, go to IN_SPIKE, pk=x, pk_ts=ts.
  - IN_SPIKE: on an accepted sample:
    - If x is above Thr and x > pk, update pk and pk_ts. Ties keep the earlier ts.
    - If x is not above Thr, the spike ends: go to REFRACT with rc=Refractory.
  - REFRACT: decrement rc per accepted sample, with no comparisons. When the decrement takes rc to 0, go to ARMED; the next accepted sample is compared.
- Spike end: register Spike=1, Peak=pk, Spike_ts=pk_ts, and increment Spike_count.
- Armed = 1 in every state except WARMUP.
- Peak, Spike_ts and Spike_count hold their values between events.
- A cycle with Valid=0 changes no state, counter or accumulator.

## Timing
- Reset (rst=1 at a clock edge) sets every output to 0: Armed, Spike, Peak, Spike_ts, Spike_count. It also clears ts, the accumulator, Thr, rc and the window count, and sets the state to WARMUP.
- Reset mid-spike discards the spike; no event is emitted.
- Spike asserts for exactly one cycle, on the cycle after the edge that accepted the terminating sample.
- Armed rises on the cycle after the edge that accepted the 2^Win_log2-th sample.
- Back-to-back Valid every cycle is sustained; throughput is one sample per clock with no stall.
- A window end and a spike transition on the same sample are both honoured:
  - The FSM uses the old Thr.
  - The new Thr applies from the next accepted sample.
- Thr_mult=0 gives Thr=0, so any x ≥ 1 triggers.

## Test plan
- Baseline and detect:
  - Stimulus: rst, then 16 samples of 10 with Thr_mult=4, then 30, 50, 90, 60, 20 (ts 16..20), Valid=1 every cycle.
  - Required: Armed=1 after the 16th sample; Thr=40; a single Spike pulse one cycle after ts=20 is accepted, with Peak=90, Spike_ts=18, Spike_count=1.
- Refractory:
  - Stimulus: continue the detect case with 8 samples of 100, then one sample of 100.
  - Required: no event during the 8 held-off samples; a new spike starts on the 9th sample.
- Clamp and equality:
  - Stimulus: 16 samples of −5, Thr_mult=4; then 0, then 1.
  - Required: Thr=0; 0 does not trigger; 1 starts a spike.
- Valid gaps:
  - Stimulus: repeat the detect case with Valid=0 on alternate cycles and Data_in=32767 on the idle cycles.
  - Required: identical Peak, Spike_ts and Spike_count to the detect case; only the timing is stretched.
- Reset mid-spike:
  - Stimulus: assert rst while in IN_SPIKE.
  - Required: all outputs 0 the next cycle; Armed=0; no Spike pulse; ts restarts at 0.
- Equal-peak tie and timestamp wrap:
  - Stimulus: TS_width=4, with a spike peaking twice at 70 across the ts 15→0 wrap.
  - Required: Spike_ts=15 (earlier sample of the tie).

Source files
------------

// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector for a NEO energy stream: block-average
// threshold, peak/timestamp capture per spike, then a refractory hold-off.
module neo_spike_detector #(
  parameter int Data_width = 16,
  parameter int Win_log2   = 4,
  parameter int Refractory = 8,
  parameter int TS_width   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [Data_width-1:0] Data_in,
  input  logic                         Valid,
  input  logic        [3:0]            Thr_mult,
  output logic                         Armed,
  output logic                         Spike,
  output logic        [Data_width-1:0] Peak,
  output logic        [TS_width-1:0]   Spike_ts,
  output logic        [7:0]            Spike_count
);

  localparam int AccW = Data_width + Win_log2;
  localparam int ThrW = Data_width + 4;
  localparam logic [7:0] RefrCount = 8'(Refractory);

  typedef enum logic [1:0] {
    WARMUP,
    ARMED,
    IN_SPIKE,
    REFRACT
  } state_t;

  state_t                 state;
  logic [TS_width-1:0]    ts;
  logic [AccW-1:0]        acc;
  logic [Win_log2-1:0]    win_cnt;
  logic [ThrW-1:0]        thr;
  logic [7:0]             rc;
  logic [Data_width-1:0]  pk;
  logic [TS_width-1:0]    pk_ts;

  logic [Data_width-1:0]  x;
  logic [AccW-1:0]        sum;
  logic [ThrW-1:0]        avg_ext;
  logic [ThrW-1:0]        thr_calc;
  logic                   win_end;
  logic                   above;

  // Negative energy is treated as zero for both averaging and detection.
  assign x        = Data_in[Data_width-1] ? '0 : Data_in;
  assign sum      = acc + AccW'(x);
  assign avg_ext  = ThrW'(sum >> Win_log2);
  assign thr_calc = avg_ext * ThrW'(Thr_mult);
  assign win_end  = &win_cnt;
  assign above    = ThrW'(x) > thr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WARMUP;
      ts          <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      thr         <= '0;
      rc          <= '0;
      pk          <= '0;
      pk_ts       <= '0;
      Armed       <= 1'b0;
      Spike       <= 1'b0;
      Peak        <= '0;
      Spike_ts    <= '0;
      Spike_count <= '0;
    end else begin
      Spike <= 1'b0;
      if (Valid) begin
        ts      <= ts + TS_width'(1);
        win_cnt <= win_cnt + Win_log2'(1);
        // The FSM below still sees the old thr on a window-end sample.
        if (win_end) begin
          acc <= '0;
          thr <= thr_calc;
        end else begin
          acc <= sum;
        end

        case (state)
          WARMUP: begin
            if (win_end) begin
              state <= ARMED;
              Armed <= 1'b1;
            end
          end
          ARMED: begin
            if (above) begin
              state <= IN_SPIKE;
              pk    <= x;
              pk_ts <= ts;
            end
          end
          IN_SPIKE: begin
            if (above) begin
              if (x > pk) begin
                pk    <= x;
                pk_ts <= ts;
              end
            end else begin
              state       <= REFRACT;
              rc          <= RefrCount;
              Spike       <= 1'b1;
              Peak        <= pk;
              Spike_ts    <= pk_ts;
              Spike_count <= Spike_count + 8'd1;
            end
          end
          REFRACT: begin
            rc <= rc - 8'd1;
            if (rc == 8'd1) begin
              state <= ARMED;
            end
          end
          default: state <= WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Randomised and directed bench for neo_spike_detector against a queue-based
// behavioural model; a second instance with a 4-bit timestamp covers ts wrap.
module tb_neo_spike_detector;

  localparam int DW   = 16;
  localparam int WL   = 4;
  localparam int REFR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 Valid = 1'b0;
  logic signed [DW-1:0] Data_in = '0;
  logic [3:0]           Thr_mult = 4'd4;

  logic          armed_a, spike_a;
  logic [DW-1:0] peak_a;
  logic [15:0]   ts_a;
  logic [7:0]    count_a;
  logic          armed_b, spike_b;
  logic [DW-1:0] peak_b;
  logic [3:0]    ts_b;
  logic [7:0]    count_b;

  neo_spike_detector #(.Data_width(DW), .Win_log2(WL), .Refractory(REFR), .TS_width(16)) dut_a (
    .clk(clk), .rst(rst), .Data_in(Data_in), .Valid(Valid), .Thr_mult(Thr_mult),
    .Armed(armed_a), .Spike(spike_a), .Peak(peak_a), .Spike_ts(ts_a), .Spike_count(count_a)
  );

  neo_spike_detector #(.Data_width(DW), .Win_log2(WL), .Refractory(REFR), .TS_width(4)) dut_b (
    .clk(clk), .rst(rst), .Data_in(Data_in), .Valid(Valid), .Thr_mult(Thr_mult),
    .Armed(armed_b), .Spike(spike_b), .Peak(peak_b), .Spike_ts(ts_b), .Spike_count(count_b)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 = watching, 1 = inside a spike, 2 = holding off.
  int m_ts, m_thr, m_phase, m_hold, m_pk, m_pkts;
  bit m_armed;
  int m_win[$];
  bit exp_spike;
  int exp_peak, exp_ts, exp_count;

  logic [41:0] got_a, got_b;
  assign got_a = {armed_a, spike_a, peak_a, ts_a, count_a};
  assign got_b = {12'd0, armed_b, spike_b, peak_b, ts_b, count_b};

  function automatic logic [41:0] exp_a();
    return {m_armed, exp_spike, 16'(exp_peak), 16'(exp_ts), 8'(exp_count)};
  endfunction

  function automatic logic [41:0] exp_b();
    return {12'd0, m_armed, exp_spike, 16'(exp_peak), 4'(exp_ts % 16), 8'(exp_count)};
  endfunction

  task automatic model_reset();
    m_ts = 0; m_thr = 0; m_phase = 0; m_hold = 0; m_pk = 0; m_pkts = 0;
    m_armed = 0; m_win.delete();
    exp_spike = 0; exp_peak = 0; exp_ts = 0; exp_count = 0;
  endtask

  task automatic model_accept(input int x);
    int sum;
    if (m_armed) begin
      case (m_phase)
        0: if (x > m_thr) begin m_phase = 1; m_pk = x; m_pkts = m_ts; end
        1: begin
          if (x > m_thr) begin
            if (x > m_pk) begin m_pk = x; m_pkts = m_ts; end
          end else begin
            m_phase = 2; m_hold = REFR;
            exp_spike = 1; exp_peak = m_pk; exp_ts = m_pkts;
            exp_count = (exp_count + 1) % 256;
          end
        end
        default: begin
          m_hold--;
          if (m_hold == 0) m_phase = 0;
        end
      endcase
    end
    m_win.push_back(x);
    if (m_win.size() == (1 << WL)) begin
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      m_thr = (sum / (1 << WL)) * int'(Thr_mult);
      m_win.delete();
      m_armed = 1;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic drive(input logic r, input logic v, input int d);
    rst = r; Valid = v; Data_in = 16'(d);
    @(posedge clk);
    exp_spike = 0;
    if (r) model_reset();
    else if (v) model_accept(d < 0 ? 0 : d);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0);
    drive(1, 1, 1234);
    checks++;
    if (got_a !== 42'd0 || got_b !== 42'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%h required 0/0", got_a, got_b);
    end
  endtask

  task automatic test_detect_case(input bit gaps, input string name);
    int seq[$];
    int spikes = 0;
    for (int i = 0; i < 16; i++) seq.push_back(10);
    seq.push_back(30); seq.push_back(50); seq.push_back(90);
    seq.push_back(60); seq.push_back(20);
    Thr_mult = 4'd4;
    drive(1, 0, 0);
    foreach (seq[i]) begin
      for (int k = (gaps ? 0 : 1); k < 2; k++) begin
        if (k == 0) drive(0, 0, 32767);
        else drive(0, 1, seq[i]);
        checks++;
        if (got_a !== exp_a() || got_b !== exp_b()) begin
          errors++;
          $display("[TB] FAIL %s_cycle%0d: got %h/%h required %h/%h", name, i, got_a, got_b, exp_a(), exp_b());
        end
        if (spike_a === 1'b1) spikes++;
      end
      if (i == 15) begin
        checks++;
        if (armed_a !== 1'b1 || dut_a.thr !== 20'd40) begin
          errors++;
          $display("[TB] FAIL %s_armed_thr: armed=%b thr=%0d required 1/40", name, armed_a, dut_a.thr);
        end
      end
    end
    checks++;
    if (spike_a !== 1'b1 || peak_a !== 16'd90 || ts_a !== 16'd18 || count_a !== 8'd1 || spikes != 1) begin
      errors++;
      $display("[TB] FAIL %s_event: spike=%b peak=%0d ts=%0d count=%0d pulses=%0d required 1/90/18/1/1",
               name, spike_a, peak_a, ts_a, count_a, spikes);
    end
  endtask

  task automatic test_refractory();
    int spikes = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, (i == 9) ? 10 : 100);
      checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        errors++;
        $display("[TB] FAIL refract_cycle%0d: got %h/%h required %h/%h", i, got_a, got_b, exp_a(), exp_b());
      end
      if (i < 9 && spike_a === 1'b1) spikes++;
    end
    checks++;
    if (spikes != 0 || spike_a !== 1'b1 || peak_a !== 16'd100 || ts_a !== 16'd29 || count_a !== 8'd2) begin
      errors++;
      $display("[TB] FAIL refract_event: early=%0d spike=%b peak=%0d ts=%0d count=%0d required 0/1/100/29/2",
               spikes, spike_a, peak_a, ts_a, count_a);
    end
  endtask

  task automatic test_clamp_equality();
    int seq[$];
    int spikes = 0;
    for (int i = 0; i < 16; i++) seq.push_back(-5);
    seq.push_back(0); seq.push_back(0); seq.push_back(1); seq.push_back(0);
    Thr_mult = 4'd4;
    drive(1, 0, 0);
    foreach (seq[i]) begin
      drive(0, 1, seq[i]);
      checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        errors++;
        $display("[TB] FAIL clamp_cycle%0d: got %h/%h required %h/%h", i, got_a, got_b, exp_a(), exp_b());
      end
      if (i < 19 && spike_a === 1'b1) spikes++;
      if (i == 15) begin
        checks++;
        if (dut_a.thr !== 20'd0 || armed_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL clamp_thr: thr=%0d armed=%b required 0/1", dut_a.thr, armed_a);
        end
      end
    end
    checks++;
    if (spikes != 0 || spike_a !== 1'b1 || peak_a !== 16'd1 || ts_a !== 16'd18) begin
      errors++;
      $display("[TB] FAIL clamp_event: early=%0d spike=%b peak=%0d ts=%0d required 0/1/1/18",
               spikes, spike_a, peak_a, ts_a);
    end
  endtask

  task automatic test_reset_mid_spike();
    int seq[$];
    Thr_mult = 4'd4;
    drive(1, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 10);
    drive(0, 1, 30); drive(0, 1, 50); drive(0, 1, 90);
    drive(1, 1, 5);
    checks++;
    if (got_a !== 42'd0 || got_b !== 42'd0) begin
      errors++;
      $display("[TB] FAIL midspike_reset: got %h/%h required 0/0", got_a, got_b);
    end
    drive(0, 0, 0);
    checks++;
    if (spike_a !== 1'b0 || armed_a !== 1'b0 || count_a !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midspike_quiet: spike=%b armed=%b count=%0d required 0/0/0", spike_a, armed_a, count_a);
    end
    for (int i = 0; i < 16; i++) seq.push_back(10);
    seq.push_back(30); seq.push_back(50); seq.push_back(90);
    seq.push_back(60); seq.push_back(20);
    foreach (seq[i]) begin
      drive(0, 1, seq[i]);
      checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        errors++;
        $display("[TB] FAIL midspike_cycle%0d: got %h/%h required %h/%h", i, got_a, got_b, exp_a(), exp_b());
      end
    end
    checks++;
    if (ts_a !== 16'd18 || peak_a !== 16'd90 || count_a !== 8'd1) begin
      errors++;
      $display("[TB] FAIL midspike_restart: ts=%0d peak=%0d count=%0d required 18/90/1", ts_a, peak_a, count_a);
    end
  endtask

  task automatic test_tie_wrap();
    int seq[$];
    for (int i = 0; i < 30; i++) seq.push_back(10);
    seq.push_back(50); seq.push_back(70); seq.push_back(70); seq.push_back(10);
    Thr_mult = 4'd4;
    drive(1, 0, 0);
    foreach (seq[i]) begin
      drive(0, 1, seq[i]);
      checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        errors++;
        $display("[TB] FAIL tie_cycle%0d: got %h/%h required %h/%h", i, got_a, got_b, exp_a(), exp_b());
      end
    end
    checks++;
    if (spike_b !== 1'b1 || ts_b !== 4'd15 || peak_b !== 16'd70 || ts_a !== 16'd31 || dut_a.thr !== 20'd64) begin
      errors++;
      $display("[TB] FAIL tie_wrap: spike=%b ts4=%0d peak=%0d ts16=%0d thr=%0d required 1/15/70/31/64",
               spike_b, ts_b, peak_b, ts_a, dut_a.thr);
    end
  endtask

  task automatic test_random();
    int d;
    bit v, r;
    drive(1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) Thr_mult = ($urandom % 8 == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      v = ($urandom % 4) != 0;
      r = ($urandom % 400) == 0;
      if ($urandom % 8 == 0) d = int'($urandom_range(200, 3000));
      else d = int'($urandom_range(0, 80)) - 20;
      drive(r, v, d);
      checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %h/%h required %h/%h", i, got_a, got_b, exp_a(), exp_b());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_detect_case(1'b0, "detect");
    test_refractory();
    test_clamp_equality();
    test_detect_case(1'b1, "gaps");
    test_reset_mid_spike();
    test_tie_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
